// File: rtl/true_dpram_sclk_pkg.sv
// true_dpram_sclk_pkg: default geometry shared by the dual-port RAM and its users
package true_dpram_sclk_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 6;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
endpackage

// File: rtl/true_dpram_sclk.sv
// true_dpram_sclk: 64x8 true dual-port RAM, one clock; ports A/B = data_*, addr_*, we_* in, q_* registered out (write-first per port, old data across ports, A wins collisions)
module true_dpram_sclk
    import true_dpram_sclk_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] data_a,
    input  logic [DW-1:0] data_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic          we_a,
    input  logic          we_b,
    output logic [DW-1:0] q_a,
    output logic [DW-1:0] q_b
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] q_a_d, q_a_q, q_b_d, q_b_q;
    logic          wr_a, wr_b;
    always_comb begin
        wr_a  = (we_a == 1'b1);
        wr_b  = (we_b == 1'b1);
        q_a_d = wr_a ? data_a : mem[addr_a];
        q_b_d = wr_b ? data_b : mem[addr_b];
    end
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_b) mem[addr_b] <= data_b;
            if (wr_a) mem[addr_a] <= data_a;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_a_q <= '0;
            q_b_q <= '0;
        end else begin
            q_a_q <= q_a_d;
            q_b_q <= q_b_d;
        end
    end
    assign q_a = q_a_q;
    assign q_b = q_b_q;
endmodule

// File: tb/tb_true_dpram_sclk.sv
// tb_true_dpram_sclk: directed vector table plus randomized run against an array reference model
module tb_true_dpram_sclk;
    logic       clk = 1'b0;
    logic       rst_n, we_a, we_b;
    logic [5:0] addr_a, addr_b;
    logic [7:0] data_a, data_b, q_a, q_b;
    int         tests = 0;
    int         fails = 0;

    true_dpram_sclk dut (
        .clk(clk), .rst_n(rst_n),
        .data_a(data_a), .data_b(data_b),
        .addr_a(addr_a), .addr_b(addr_b),
        .we_a(we_a), .we_b(we_b),
        .q_a(q_a), .q_b(q_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       we_a;
        logic [5:0] addr_a;
        logic [7:0] data_a;
        logic       we_b;
        logic [5:0] addr_b;
        logic [7:0] data_b;
        logic [7:0] ea;
        logic [7:0] eb;
        bit         ca;
        bit         cb;
    } vec_t;

    vec_t       tbl [16];
    logic [7:0] ref_mem [64];
    bit         ref_vld [64];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic wa, input logic [5:0] aa, input logic [7:0] da,
                         input logic wb, input logic [5:0] ab, input logic [7:0] db);
        rst_n = r; we_a = wa; addr_a = aa; data_a = da; we_b = wb; addr_b = ab; data_b = db;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
        tbl[0]  = '{1'b0, 1'b1, 6'd5,  8'hAA, 1'b0, 6'd0,  8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 6'd5,  8'hAA, 1'b0, 6'd0,  8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 6'd5,  8'h55, 1'b0, 6'd0,  8'h00, 8'h55, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 6'd5,  8'hAA, 1'b1, 6'd5,  8'hBB, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 6'd5,  8'h00, 1'b0, 6'd5,  8'h00, 8'h55, 8'h55, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 6'd10, 8'h3C, 1'b0, 6'd5,  8'h00, 8'h3C, 8'h55, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 6'd10, 8'h00, 1'b0, 6'd10, 8'h00, 8'h3C, 8'h3C, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 6'd10, 8'h00, 1'b1, 6'd63, 8'h5A, 8'h3C, 8'h5A, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 6'd63, 8'h00, 1'b0, 6'd63, 8'h00, 8'h5A, 8'h5A, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 6'd20, 8'h11, 1'b0, 6'd63, 8'h00, 8'h11, 8'h5A, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 6'd20, 8'h22, 1'b0, 6'd20, 8'h00, 8'h22, 8'h11, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 6'd20, 8'h00, 1'b0, 6'd20, 8'h00, 8'h22, 8'h22, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 6'd0,  8'h77, 1'b1, 6'd0,  8'h88, 8'h77, 8'h88, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 6'd0,  8'h00, 1'b0, 6'd0,  8'h00, 8'h77, 8'h77, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 6'd1,  8'h01, 1'b1, 6'd2,  8'h02, 8'h01, 8'h02, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 6'd2,  8'h00, 1'b0, 6'd1,  8'h00, 8'h02, 8'h01, 1'b1, 1'b1};
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst_n, tbl[i].we_a, tbl[i].addr_a, tbl[i].data_a,
                  tbl[i].we_b, tbl[i].addr_b, tbl[i].data_b);
            if (tbl[i].ca) chk($sformatf("vec%0d q_a", i), q_a, tbl[i].ea);
            if (tbl[i].cb) chk($sformatf("vec%0d q_b", i), q_b, tbl[i].eb);
        end

        // Write, hold reset for several cycles with conflicting writes, then confirm retention.
        drive(1'b1, 1'b1, 6'd40, 8'hC3, 1'b1, 6'd41, 8'h3C);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 6'd40, 8'hFF, 1'b1, 6'd41, 8'hFF);
        chk("rst_hold q_a", q_a, 8'h00);
        chk("rst_hold q_b", q_b, 8'h00);
        drive(1'b1, 1'b0, 6'd41, 8'h00, 1'b0, 6'd40, 8'h00);
        chk("retain q_a", q_a, 8'h3C);
        chk("retain q_b", q_b, 8'hC3);

        // Back-to-back writes on B to one address while A trails it by a cycle.
        drive(1'b1, 1'b0, 6'd50, 8'h00, 1'b1, 6'd50, 8'h10);
        drive(1'b1, 1'b0, 6'd50, 8'h00, 1'b1, 6'd50, 8'h20);
        chk("b2b old q_a", q_a, 8'h10);
        chk("b2b own q_b", q_b, 8'h20);
        drive(1'b1, 1'b0, 6'd50, 8'h00, 1'b0, 6'd50, 8'h00);
        chk("b2b new q_a", q_a, 8'h20);

        for (int i = 0; i < 64; i++) ref_vld[i] = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            logic       r, wa, wb;
            logic [5:0] aa, ab;
            logic [7:0] da, db, ea, eb;
            bit         va, vb;
            r  = ($urandom_range(0, 99) >= 3);
            wa = $urandom_range(0, 1) == 1;
            wb = $urandom_range(0, 1) == 1;
            aa = $urandom_range(0, 1) == 1 ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            ab = $urandom_range(0, 1) == 1 ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            da = 8'($urandom);
            db = 8'($urandom);
            if (!r) begin
                ea = 8'h00; eb = 8'h00; va = 1'b1; vb = 1'b1;
            end else begin
                ea = wa ? da : ref_mem[aa];
                eb = wb ? db : ref_mem[ab];
                va = wa || ref_vld[aa];
                vb = wb || ref_vld[ab];
                if (wb) begin ref_mem[ab] = db; ref_vld[ab] = 1'b1; end
                if (wa) begin ref_mem[aa] = da; ref_vld[aa] = 1'b1; end
            end
            drive(r, wa, aa, da, wb, ab, db);
            if (va) chk($sformatf("rand%0d q_a", n), q_a, ea);
            if (vb) chk($sformatf("rand%0d q_b", n), q_b, eb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
